// File: rtl/ps2_move_pkg.sv
// Shared constants for the PS/2 move queue: move codes, scan codes, parser states.
package ps2_move_pkg;

  // Move codes presented to the position update stage
  localparam logic [2:0] MOVE_NONE   = 3'd0;
  localparam logic [2:0] MOVE_UP     = 3'd1;
  localparam logic [2:0] MOVE_DOWN   = 3'd2;
  localparam logic [2:0] MOVE_LEFT   = 3'd3;
  localparam logic [2:0] MOVE_RIGHT  = 3'd4;
  localparam logic [2:0] MOVE_ACTION = 3'd5;

  // Set-2 prefixes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  // Plain make codes
  localparam logic [7:0] SC_UP     = 8'h1D;
  localparam logic [7:0] SC_DOWN   = 8'h1B;
  localparam logic [7:0] SC_LEFT   = 8'h1C;
  localparam logic [7:0] SC_RIGHT  = 8'h23;
  localparam logic [7:0] SC_ACTION = 8'h29;

  // Extended (E0-prefixed) make codes: cursor keys
  localparam logic [7:0] SC_EXT_UP    = 8'h75;
  localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
  localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
  localparam logic [7:0] SC_EXT_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } parser_state_e;

endpackage

// File: rtl/ps2_move_queue_if.sv
// Byte-in / move-out bundle of the PS/2 move queue.
interface ps2_move_queue_if #(
  parameter int DEPTH  = 4,
  parameter int MOVE_W = 3
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              rx_done_tick;
  logic [7:0]        rx_data;
  logic              frame_tick;
  logic              flush;
  logic [MOVE_W-1:0] move_out;
  logic              move_valid;
  logic [CW-1:0]     count;
  logic              empty;
  logic              overflow;

  modport master (
    output rx_done_tick, rx_data, frame_tick, flush,
    input  move_out, move_valid, count, empty, overflow
  );

  modport slave (
    input  rx_done_tick, rx_data, frame_tick, flush,
    output move_out, move_valid, count, empty, overflow
  );
endinterface

// File: rtl/move_fifo.sv
// Small synchronous FIFO of move codes; flush has priority over push and pop.
module move_fifo #(
  parameter int DEPTH  = 4,
  parameter int MOVE_W = 3,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [MOVE_W-1:0] wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [MOVE_W-1:0] rdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);
  logic [MOVE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ps2_move_queue.sv
// PS/2 scan-code parser feeding a move FIFO that releases one move per frame tick.
// Optional typematic repeat filter: define PS2_MOVE_REPEAT_FILTER_EN.
module ps2_move_queue
  import ps2_move_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int MOVE_W = 3
) (
  input logic            clk,
  input logic            resetn,
  ps2_move_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  parser_state_e     state_q, state_d;
  logic              make_vld, make_ext, brk_vld, brk_ext;
  logic [2:0]        make_code;
  logic              make_mapped;
  logic              push;
  logic [MOVE_W-1:0] head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;

  function automatic logic [2:0] map_code(input logic ext, input logic [7:0] sc);
    logic [2:0] m;
    m = MOVE_NONE;
    if (!ext) begin
      case (sc)
        SC_UP:     m = MOVE_UP;
        SC_DOWN:   m = MOVE_DOWN;
        SC_LEFT:   m = MOVE_LEFT;
        SC_RIGHT:  m = MOVE_RIGHT;
        SC_ACTION: m = MOVE_ACTION;
        default:   m = MOVE_NONE;
      endcase
    end else begin
      case (sc)
        SC_EXT_UP:    m = MOVE_UP;
        SC_EXT_DOWN:  m = MOVE_DOWN;
        SC_EXT_LEFT:  m = MOVE_LEFT;
        SC_EXT_RIGHT: m = MOVE_RIGHT;
        default:      m = MOVE_NONE;
      endcase
    end
    return m;
  endfunction

  // Parser state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Parser next state; classifies each completed byte as a make or a break
  always_comb begin
    state_d  = state_q;
    make_vld = 1'b0;
    make_ext = 1'b0;
    brk_vld  = 1'b0;
    brk_ext  = 1'b0;
    if (bus.rx_done_tick) begin
      unique case (state_q)
        StIdle: begin
          if (bus.rx_data == SC_E0)      state_d = StExt;
          else if (bus.rx_data == SC_F0) state_d = StBrk;
          else                           make_vld = 1'b1;
        end
        StExt: begin
          if (bus.rx_data == SC_F0) begin
            state_d = StExtBrk;
          end else begin
            make_vld = 1'b1;
            make_ext = 1'b1;
            state_d  = StIdle;
          end
        end
        StBrk: begin
          brk_vld = 1'b1;
          state_d = StIdle;
        end
        StExtBrk: begin
          brk_vld = 1'b1;
          brk_ext = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    if (bus.flush) state_d = StIdle;
  end

  assign make_code   = map_code(make_ext, bus.rx_data);
  assign make_mapped = make_vld & (make_code != MOVE_NONE);

`ifdef PS2_MOVE_REPEAT_FILTER_EN
  logic [8:0] held_q;
  logic       held_vld_q;
  logic       same_key;

  assign same_key = held_vld_q & (held_q == {make_ext, bus.rx_data});
  assign push     = make_mapped & ~same_key;

  // Held-key tracker: a new make replaces it, the matching break releases it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held_q     <= '0;
      held_vld_q <= 1'b0;
    end else if (bus.flush) begin
      held_q     <= '0;
      held_vld_q <= 1'b0;
    end else if (push) begin
      held_q     <= {make_ext, bus.rx_data};
      held_vld_q <= 1'b1;
    end else if (brk_vld && held_vld_q && held_q == {brk_ext, bus.rx_data}) begin
      held_vld_q <= 1'b0;
    end
  end
`else
  logic unused_brk;
  assign unused_brk = brk_vld ^ brk_ext;
  assign push       = make_mapped;
`endif

  move_fifo #(
    .DEPTH  (DEPTH),
    .MOVE_W (MOVE_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (MOVE_W'(make_code)),
    .pop    (bus.frame_tick),
    .flush  (bus.flush),
    .rdata  (head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Frame result register: an empty frame still reports a valid NONE move
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.move_out   <= '0;
      bus.move_valid <= 1'b0;
    end else if (bus.flush) begin
      bus.move_out   <= MOVE_W'(MOVE_NONE);
      bus.move_valid <= 1'b0;
    end else if (bus.frame_tick) begin
      bus.move_out   <= fifo_empty ? MOVE_W'(MOVE_NONE) : head;
      bus.move_valid <= 1'b1;
    end else begin
      bus.move_valid <= 1'b0;
    end
  end

  // Sticky drop flag; only reset clears it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.overflow <= 1'b0;
    end else if (push && fifo_full && !bus.frame_tick && !bus.flush) begin
      bus.overflow <= 1'b1;
    end
  end

  assign bus.count = fifo_count;
  assign bus.empty = fifo_empty;

endmodule

// File: tb/tb_ps2_move_queue.sv
// Randomised bench for ps2_move_queue with a queue-based reference model and scoreboard.
module tb_ps2_move_queue;
  localparam int DEPTH  = 4;
  localparam int MOVE_W = 3;
  localparam int B_E0   = 'hE0;
  localparam int B_F0   = 'hF0;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #10 clk = ~clk;

  ps2_move_queue_if #(.DEPTH(DEPTH), .MOVE_W(MOVE_W)) bus ();

  ps2_move_queue #(.DEPTH(DEPTH), .MOVE_W(MOVE_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int mq[$];      // queued moves
  int sb[$];      // expected frame results awaiting the DUT pulse
  int pend[$];    // bytes of the scan-code sequence in progress
  int m_ovf  = 0;
  int m_hold = 0;
  int m_held = -1;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_map(input bit ext, input int sc);
    if (!ext) begin
      case (sc)
        'h1D: return 1;
        'h1B: return 2;
        'h1C: return 3;
        'h23: return 4;
        'h29: return 5;
        default: return 0;
      endcase
    end else begin
      case (sc)
        'h75: return 1;
        'h72: return 2;
        'h6B: return 3;
        'h74: return 4;
        default: return 0;
      endcase
    end
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    pend.delete();
    m_ovf  = 0;
    m_hold = 0;
    m_held = -1;
  endtask

  task automatic model_step(input bit rv, input int b, input bit ft, input bit fl);
    int pre;
    int mv;
    bit ext;
    bit brk;
    bit accept;
    if (fl) begin
      mq.delete();
      pend.delete();
      m_held = -1;
      m_hold = 0;
      return;
    end
    pre = mq.size();
    if (ft) begin
      if (pre > 0) m_hold = mq.pop_front();
      else         m_hold = 0;
      sb.push_back(m_hold);
    end
    if (!rv) return;
    pend.push_back(b);
    // Sequence still open: a lone prefix, or E0 F0
    if ((pend.size() == 1 && (b == B_E0 || b == B_F0)) ||
        (pend.size() == 2 && pend[0] == B_E0 && b == B_F0)) return;
    ext = (pend.size() > 1) && (pend[0] == B_E0);
    brk = (pend.size() > 1) && (pend[pend.size()-2] == B_F0);
    pend.delete();
    if (brk) begin
`ifdef PS2_MOVE_REPEAT_FILTER_EN
      if (m_held == (ext ? 256 : 0) + b) m_held = -1;
`endif
      return;
    end
    mv = ref_map(ext, b);
    if (mv == 0) return;
    accept = 1'b1;
`ifdef PS2_MOVE_REPEAT_FILTER_EN
    if (m_held == (ext ? 256 : 0) + b) accept = 1'b0;
    else                              m_held = (ext ? 256 : 0) + b;
`endif
    if (accept) begin
      if (pre < DEPTH || (ft && pre > 0)) mq.push_back(mv);
      else                                m_ovf = 1;
    end
  endtask

  // One clock of stimulus, applied at the falling edge
  task automatic step(input bit rv, input int b, input bit ft, input bit fl);
    @(negedge clk);
    bus.rx_done_tick = rv;
    bus.rx_data      = 8'(b);
    bus.frame_tick   = ft;
    bus.flush        = fl;
    model_step(rv, b, ft, fl);
  endtask

  task automatic send(input int b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard on each move_valid pulse and tracks visible state
  always begin
    @(posedge clk);
    #1;
    if (mon_en && resetn) begin
      if (bus.move_valid === 1'b1) begin
        if (sb.size() == 0) check("spurious_valid", 32'(bus.move_valid), 32'd0);
        else                check("frame_move", 32'(bus.move_out), 32'(sb.pop_front()));
      end else if (sb.size() > 0) begin
        void'(sb.pop_front());
        check("missing_valid", 32'(bus.move_valid), 32'd1);
      end
      check("move_hold", 32'(bus.move_out), 32'(m_hold));
      check("count", 32'(bus.count), 32'(mq.size()));
      check("empty", 32'(bus.empty), 32'(mq.size() == 0));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
    end
  end

  initial begin
    int r;
    int b;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.frame_tick   = 1'b0;
    bus.flush        = 1'b0;
    model_reset();
    #5;
    check("rst_move_out", 32'(bus.move_out), 32'd0);
    check("rst_move_valid", 32'(bus.move_valid), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Make, break, one frame
    send('h1D); send('hF0); send('h1D);
    tick(); idle();

    // Extended make and extended break, two frames
    send('hE0); send('h74); send('hE0); send('hF0); send('h74);
    tick(); tick();

    // Overfill, then drain in order
    send('h23); send('h1C); send('h1B); send('h1D); send('h29); idle();
    @(posedge clk); #1;
    check("full_count", 32'(bus.count), 32'd4);
    check("full_overflow", 32'(bus.overflow), 32'd1);
    tick(); tick(); tick(); tick();

    // Full FIFO with push and pop together
    send('h23); send('h1C); send('h1B); send('h1D);
    step(1'b1, 'h1D, 1'b1, 1'b0); idle();
    repeat (5) tick();

    // Flush beats a simultaneous frame tick; stray extended code alone is ignored
    send('h1D); send('h1B);
    step(1'b0, 0, 1'b1, 1'b1); idle();
    send('h74); idle();

    // Typematic repeats
    step(1'b0, 0, 1'b0, 1'b1);
    send('h1D); send('h1D); send('h1D); send('hF0); send('h1D); send('h1D); idle();
    @(posedge clk); #1;
`ifdef PS2_MOVE_REPEAT_FILTER_EN
    check("repeat_count", 32'(bus.count), 32'd2);
`else
    check("repeat_count", 32'(bus.count), 32'd4);
`endif

    // Reset in the middle of an E0 sequence discards the prefix
    send('hE0);
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    send('h74); idle();
    tick();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 13);
      case (r)
        0: b = 'h1D;  1: b = 'h1B;  2: b = 'h1C;  3: b = 'h23;  4: b = 'h29;
        5: b = 'h75;  6: b = 'h72;  7: b = 'h6B;  8: b = 'h74;
        9, 10: b = B_E0;
        11, 12: b = B_F0;
        default: b = $urandom_range(0, 255);
      endcase
      step(($urandom_range(0, 2) == 0), b, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 149) == 0));
    end
    idle(); idle(); idle();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
